// File: rtl/fb_rect_fill_if.sv
// fb_rect_fill_if: command handshake and BlockRam write port of the rectangle filler
// Signals:
//   cmd_valid, cmd_ready                  command handshake
//   cmd_x0, cmd_y0, cmd_x1, cmd_y1        opposite rectangle corners, inclusive
//   cmd_color                             RGB555 fill color
//   wr_address, wr_data, wr_en            BlockRam write port, address {x, y}
//   busy, done                            command status
// slave is the filler, master is the command source and RAM side.
interface fb_rect_fill_if #(
  parameter int COORD_WIDTH = 8,
  parameter int COLOR_WIDTH = 15
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [COORD_WIDTH-1:0]   cmd_x0;
  logic [COORD_WIDTH-1:0]   cmd_y0;
  logic [COORD_WIDTH-1:0]   cmd_x1;
  logic [COORD_WIDTH-1:0]   cmd_y1;
  logic [COLOR_WIDTH-1:0]   cmd_color;
  logic [2*COORD_WIDTH-1:0] wr_address;
  logic [COLOR_WIDTH-1:0]   wr_data;
  logic                     wr_en;
  logic                     busy;
  logic                     done;
  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
    output cmd_ready, wr_address, wr_data, wr_en, busy, done
  );
  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
    input  cmd_ready, wr_address, wr_data, wr_en, busy, done
  );
endinterface

// File: rtl/fb_rect_fill.sv
// fb_rect_fill: streams one frame-buffer pixel write per clock for each rectangle-fill command
// Ports:
//   clock  system clock, rising edge
//   reset  synchronous active-low reset
//   bus    fb_rect_fill_if.slave: command handshake in, BlockRam write port and status out
// All outputs are registered; they are loaded from the next-state decode so the first
// pixel appears on the accept edge and done follows the last write by one cycle.
module fb_rect_fill #(
  parameter int COORD_WIDTH = 8,
  parameter int COLOR_WIDTH = 15
) (
  input  logic          clock,
  input  logic          reset,
  fb_rect_fill_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t state, nxt;
  logic [COORD_WIDTH-1:0] x, y, x_min, x_max, y_min, y_max;
  logic [COORD_WIDTH-1:0] lo_x, hi_x, lo_y, hi_y, n_x, n_y;
  logic [COLOR_WIDTH-1:0] color, n_color;
  logic accept, x_end, last;
  always_ff @(posedge clock)
    if (!reset) state <= IDLE;
    else state <= nxt;
  // x,y always name the pixel currently on the write port; end tests compare before stepping
  always_comb begin
    accept = state == IDLE && bus.cmd_valid;
    x_end  = x == x_max;
    last   = x_end && y == y_max;
    nxt    = state == IDLE ? (bus.cmd_valid ? FILL : IDLE) :
             state == FILL ? (last ? DONE : FILL) : IDLE;
  end
  always_comb begin
    lo_x    = bus.cmd_x0 < bus.cmd_x1 ? bus.cmd_x0 : bus.cmd_x1;
    hi_x    = bus.cmd_x0 < bus.cmd_x1 ? bus.cmd_x1 : bus.cmd_x0;
    lo_y    = bus.cmd_y0 < bus.cmd_y1 ? bus.cmd_y0 : bus.cmd_y1;
    hi_y    = bus.cmd_y0 < bus.cmd_y1 ? bus.cmd_y1 : bus.cmd_y0;
    n_x     = accept ? lo_x : x_end ? x_min : x + 1'b1;
    n_y     = accept ? lo_y : x_end ? y + 1'b1 : y;
    n_color = accept ? bus.cmd_color : color;
  end
  always_ff @(posedge clock)
    if (!reset) begin
      x              <= '0;
      y              <= '0;
      x_min          <= '0;
      x_max          <= '0;
      y_min          <= '0;
      y_max          <= '0;
      color          <= '0;
      bus.wr_address <= '0;
      bus.wr_data    <= '0;
      bus.wr_en      <= 1'b0;
      bus.cmd_ready  <= 1'b1;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      if (accept) begin
        x_min <= lo_x;
        x_max <= hi_x;
        y_min <= lo_y;
        y_max <= hi_y;
        color <= bus.cmd_color;
      end
      if (nxt == FILL) begin
        x              <= n_x;
        y              <= n_y;
        bus.wr_address <= {n_x, n_y};
        bus.wr_data    <= n_color;
      end
      bus.wr_en     <= nxt == FILL;
      bus.cmd_ready <= nxt == IDLE;
      bus.busy      <= nxt != IDLE;
      bus.done      <= nxt == DONE;
    end
endmodule
